// File: rtl/p_box_seq.sv
// Sequential W-bit permutation box with a runtime-loadable table, applied a
// programmable number of rounds. Inverse mode is built only with P_BOX_SEQ_INV_EN.
module p_box_seq #(
   parameter int W = 8,
   parameter int IDXW = $clog2(W),
   parameter int RW = 4,
   parameter logic [W*IDXW-1:0] INIT_PERM = 24'h4F19C5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [W-1:0]    I,
   input  logic            inv,
   input  logic [RW-1:0]   rounds,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [W-1:0]    O,
   output logic            out_valid,
   input  logic            out_ready,
   input  logic            cfg_we,
   input  logic [IDXW-1:0] cfg_idx,
   input  logic [IDXW-1:0] cfg_src,
   output logic            busy,
   output logic            perm_ok
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                   state;
   logic [W-1:0]             work;
   logic [RW-1:0]            cnt;
   logic [W-1:0][IDXW-1:0]   tbl, tbl_next;
   logic                     ok_next;
   logic [W-1:0]             fwd, step;

   assign O = work;

   // Table writes only land in IDLE, so an in-flight operation sees a fixed table.
   always_comb begin
      tbl_next = tbl;
      if (state == IDLE && cfg_we && int'(cfg_idx) < W)
         tbl_next[cfg_idx] = cfg_src;
   end

   // perm_ok is evaluated on the post-write table so it is valid right after the write edge.
   always_comb begin
      logic [W-1:0] seen;
      seen    = '0;
      ok_next = 1'b1;
      for (int k = 0; k < W; k++) begin
         if (int'(tbl_next[k]) >= W || seen[tbl_next[k]])
            ok_next = 1'b0;
         else
            seen[tbl_next[k]] = 1'b1;
      end
   end

   for (genvar k = 0; k < W; k++) begin : g_fwd
      assign fwd[k] = (int'(tbl[k]) < W) ? work[tbl[k]] : 1'b0;
   end

`ifdef P_BOX_SEQ_INV_EN
   logic         inv_r;
   logic [W-1:0] bwd;

   for (genvar j = 0; j < W; j++) begin : g_bwd
      logic [W-1:0] hit;
      for (genvar k = 0; k < W; k++) begin : g_hit
         assign hit[k] = work[k] & (tbl[k] == IDXW'(j));
      end
      assign bwd[j] = |hit;
   end

   assign step = inv_r ? bwd : fwd;
`else
   logic unused_inv;
   assign unused_inv = inv;
   assign step = fwd;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         work      <= '0;
         cnt       <= '0;
         tbl       <= INIT_PERM;
         perm_ok   <= 1'b1;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef P_BOX_SEQ_INV_EN
         inv_r     <= 1'b0;
`endif
      end else begin
         tbl     <= tbl_next;
         perm_ok <= ok_next;
         case (state)
            IDLE: if (in_valid) begin
               work     <= I;
               cnt      <= rounds;
`ifdef P_BOX_SEQ_INV_EN
               inv_r    <= inv;
`endif
               in_ready <= 1'b0;
               busy     <= 1'b1;
               if (rounds == '0) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  state <= BUSY;
               end
            end
            BUSY: begin
               work <= step;
               cnt  <= cnt - RW'(1);
               if (cnt == RW'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
